// File: rtl/wb_pkg.sv
// Shared widths, FSM encoding, CTI codes and bus payload type for the Wishbone arbiter.
package wb_pkg;

    localparam int unsigned ADR_W = 30;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned CTI_W = 3;
    localparam int unsigned WD_W  = 8;

    localparam logic [WD_W-1:0]  TIMEOUT_DEFAULT = 8'd255;

    localparam logic [CTI_W-1:0] CTI_CLASSIC = 3'b000;
    localparam logic [CTI_W-1:0] CTI_INCR    = 3'b010;
    localparam logic [CTI_W-1:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    // Master-to-slave request payload
    typedef struct packed {
        logic             cyc;
        logic             stb;
        logic             we;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic [SEL_W-1:0] sel;
        logic [CTI_W-1:0] cti;
    } wb_req_t;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts strobe cycles without termination and fires once at TIMEOUT.
module wb_watchdog
    import wb_pkg::*;
#(
    parameter logic [WD_W-1:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stb,
    input  logic term,
    output logic fire_c
);

    logic [WD_W-1:0] cnt_q;

    // A real termination in the same cycle suppresses the timeout
    assign fire_c = stb && !term && (cnt_q == TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!stb || term || fire_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + WD_W'(1);
        end
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter (CPU = m0, DMA = m1) with bus watchdog.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority to m0.
module wb_arbiter2
    import wb_pkg::*;
#(
    parameter logic [WD_W-1:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        CLK_I,
    input  logic        reset_n,

    input  logic        m0_CYC_I,
    input  logic        m0_STB_I,
    input  logic        m0_WE_I,
    input  logic        m0_RMW_I,
    input  logic [31:2] m0_ADR_I,
    input  logic [31:0] m0_DAT_I,
    input  logic [3:0]  m0_SEL_I,
    input  logic [2:0]  m0_CTI_I,
    output logic [31:0] m0_DAT_O,
    output logic        m0_ACK_O,
    output logic        m0_ERR_O,
    output logic        m0_RTY_O,

    input  logic        m1_CYC_I,
    input  logic        m1_STB_I,
    input  logic        m1_WE_I,
    input  logic        m1_RMW_I,
    input  logic [31:2] m1_ADR_I,
    input  logic [31:0] m1_DAT_I,
    input  logic [3:0]  m1_SEL_I,
    input  logic [2:0]  m1_CTI_I,
    output logic [31:0] m1_DAT_O,
    output logic        m1_ACK_O,
    output logic        m1_ERR_O,
    output logic        m1_RTY_O,

    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    output logic [31:2] ADR_O,
    output logic [31:0] DAT_O,
    output logic [3:0]  SEL_O,
    output logic [2:0]  CTI_O,

    input  logic [31:0] DAT_I,
    input  logic        ACK_I,
    input  logic        ERR_I,
    input  logic        RTY_I,

    output logic [1:0]  gnt_o,
    output logic        timeout_o
);

    state_t  state_q, state_d, tie_pick;
    wb_req_t m0_req, m1_req, bus_req;
    logic    gnt0, gnt1, term, wd_fire_c;

    assign m0_req = '{cyc: m0_CYC_I, stb: m0_STB_I, we: m0_WE_I, adr: m0_ADR_I,
                      dat: m0_DAT_I, sel: m0_SEL_I, cti: m0_CTI_I};
    assign m1_req = '{cyc: m1_CYC_I, stb: m1_STB_I, we: m1_WE_I, adr: m1_ADR_I,
                      dat: m1_DAT_I, sel: m1_SEL_I, cti: m1_CTI_I};

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic last_q;  // 1: master 1 was served last

    always_ff @(posedge CLK_I or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (state_q == IDLE && state_d == GNT0) begin
            last_q <= 1'b0;
        end else if (state_q == IDLE && state_d == GNT1) begin
            last_q <= 1'b1;
        end
    end

    assign tie_pick = last_q ? GNT0 : GNT1;
`else
    assign tie_pick = GNT0;
`endif

    always_ff @(posedge CLK_I or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant FSM: every grant passes through IDLE, RMW holds the grant across CYC gaps
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m0_CYC_I && m1_CYC_I) begin
                    state_d = tie_pick;
                end else if (m0_CYC_I) begin
                    state_d = GNT0;
                end else if (m1_CYC_I) begin
                    state_d = GNT1;
                end
            end
            GNT0:    if (!m0_CYC_I && !m0_RMW_I) state_d = IDLE;
            GNT1:    if (!m1_CYC_I && !m1_RMW_I) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign gnt0 = (state_q == GNT0);
    assign gnt1 = (state_q == GNT1);

    always_comb begin
        gnt_o = 2'b00;
        case (state_q)
            GNT0:    gnt_o = 2'b01;
            GNT1:    gnt_o = 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    // Slave bus follows the granted master; quiet in IDLE
    always_comb begin
        bus_req     = '0;
        bus_req.cti = CTI_CLASSIC;
        if (gnt0) begin
            bus_req = m0_req;
        end else if (gnt1) begin
            bus_req = m1_req;
        end
    end

    assign term = ACK_I | ERR_I | RTY_I;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (CLK_I),
        .rst_n  (reset_n),
        .stb    (bus_req.stb),
        .term   (term),
        .fire_c (wd_fire_c)
    );

    assign CYC_O     = bus_req.cyc;
    assign STB_O     = bus_req.stb & ~wd_fire_c;
    assign WE_O      = bus_req.we;
    assign ADR_O     = bus_req.adr;
    assign DAT_O     = bus_req.dat;
    assign SEL_O     = bus_req.sel;
    assign CTI_O     = bus_req.cti;
    assign timeout_o = wd_fire_c;

    // Read data is gated so every output reads zero while reset is held
    assign m0_DAT_O = reset_n ? DAT_I : '0;
    assign m1_DAT_O = reset_n ? DAT_I : '0;

    assign m0_ACK_O = gnt0 & ACK_I;
    assign m0_ERR_O = gnt0 & (ERR_I | wd_fire_c);
    assign m0_RTY_O = gnt0 & RTY_I;
    assign m1_ACK_O = gnt1 & ACK_I;
    assign m1_ERR_O = gnt1 & (ERR_I | wd_fire_c);
    assign m1_RTY_O = gnt1 & RTY_I;

endmodule

// File: doc/wb_arbiter2.md
WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 8'd255: maximum number of cycles STB_O may stay asserted without ACK_I, ERR_I or RTY_I.
REQ-002 The block SHALL have port CLK_I, input, 1 bit: the single clock.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports m0_CYC_I, m0_STB_I, m0_WE_I, m0_RMW_I, input, 1 bit each: Wishbone master 0 (CPU) controls.
REQ-005 The block SHALL have ports m0_ADR_I [31:2], m0_DAT_I [31:0], m0_SEL_I [3:0] and m0_CTI_I [2:0], inputs: master 0 address, write data, byte select and cycle type.
REQ-006 The block SHALL have ports m0_DAT_O [31:0], m0_ACK_O, m0_ERR_O and m0_RTY_O, outputs: master 0 read data and termination.
REQ-007 The block SHALL have a m1_* port set identical to REQ-004..006 for master 1 (DMA).
REQ-008 The block SHALL have outputs CYC_O, STB_O, WE_O, ADR_O [31:2], DAT_O [31:0], SEL_O [3:0] and CTI_O [2:0]: the shared slave bus.
REQ-009 The block SHALL have inputs DAT_I [31:0], ACK_I, ERR_I and RTY_I: slave responses.
REQ-010 The block SHALL have output gnt_o [1:0], one-hot current grant (00 = idle).
REQ-011 The block SHALL have output timeout_o, a 1-cycle pulse when the watchdog fires.

Function
REQ-012 The FSM SHALL have states IDLE, GNT0 and GNT1; the state SHALL be registered, and gnt_o SHALL decode the state.
REQ-013 In IDLE with any mN_CYC_I high, the FSM SHALL enter the GNTn selected by the priority rule (Configuration) on the next edge; arbitration latency SHALL be 1 cycle.
REQ-014 In GNTn, the FSM SHALL stay while mN_CYC_I=1 or mN_RMW_I=1, and SHALL return to IDLE when both are 0; there SHALL be no direct GNT0->GNT1 handoff (1 idle cycle minimum).
REQ-015 In GNTn, the slave bus outputs SHALL combinationally follow master n's inputs.
REQ-016 In IDLE, CYC_O, STB_O, WE_O and CTI_O SHALL be 0; ADR_O, DAT_O and SEL_O SHALL be 0.
REQ-017 DAT_I SHALL be routed to both mN_DAT_O.
REQ-018 ACK, ERR and RTY SHALL reach only the granted master; the non-granted master SHALL see 0.
REQ-019 An 8-bit watchdog counter SHALL clear when STB_O=0 or on any termination, and SHALL otherwise increment.
REQ-020 When the watchdog counter reaches TIMEOUT, the block SHALL for 1 cycle force STB_O=0, assert mN_ERR_O to the granted master, pulse timeout_o and clear the counter.
REQ-021 If termination and timeout coincide, the real termination SHALL win and timeout_o SHALL stay 0.
REQ-022 If the granted master drops CYC in the same cycle as ACK_I, the ACK SHALL still be delivered and the FSM SHALL go to IDLE on the next edge.
REQ-023 A request that rises while the other master holds the grant SHALL wait without loss until IDLE.

Reset
REQ-024 While reset_n=0, the state SHALL be IDLE, the watchdog SHALL be 0, and all outputs SHALL be 0 asynchronously, including mid-transaction.
REQ-025 After reset release, the first grant SHALL follow the rules with last-grant history = master 1.

Configuration
REQ-026 With WB_ARB_ROUND_ROBIN_EN defined, on a simultaneous request the block SHALL grant the master not served last; a 1-bit last-grant register SHALL update on each GNTn entry.
REQ-027 Without WB_ARB_ROUND_ROBIN_EN, the block SHALL use fixed priority with master 0 winning ties, and no last-grant register SHALL exist.

Structure
REQ-028 State encodings, the CTI constants (CLASSIC=3'b000, INCR=3'b010, END=3'b111) and the TIMEOUT default SHALL reside in shared package wb_pkg.
REQ-029 The watchdog SHALL be the sub-module wb_watchdog (count, clear, fire).
REQ-030 The grant FSM and muxes SHALL remain in the top level.

Verification
REQ-031 Bench SHALL drive m0 read ADR=30'h10 alone -> GNT0 next cycle; slave ACK with DAT_I=32'hCAFEBABE -> m0_ACK_O=1, m0_DAT_O=32'hCAFEBABE; m1_ACK_O=0.
REQ-032 Bench SHALL assert m0 and m1 CYC in the same cycle, 3 times back-to-back -> round-robin grants 0,1,0 (the first grant is 0 after reset); fixed-priority build grants 0,0,0.
REQ-033 Bench SHALL run m0 RMW with CYC dropped between read and write while m1 requests -> gnt_o stays 01 until RMW=0.
REQ-034 Bench SHALL hold the slave silent with TIMEOUT=4 -> on the 5th STB cycle m0_ERR_O=1, timeout_o=1, STB_O=0.
REQ-035 Bench SHALL pulse reset_n low mid-write -> CYC_O and STB_O drop immediately, gnt_o=00; after release a pending m1 request is granted in 1 cycle.
